seq_divider: RTL

Parametrised, multi-cycle radix-2 restoring integer divider with a start/done handshake. It computes quotient and remainder for a DIVIDEND-bit dividend and a DIVISOR-bit divisor, one quotient bit per clock. It adds signed mode and explicit divide-by-zero reporting. It is the area-efficient replacement for the single-cycle combinational divider and sits behind the FP package's mantissa-divide path and the integer datapath.

---
 rtl/seq_divider_if.sv | 32 +++
 rtl/seq_divider.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_divider_if
//  Description : Start/done handshake and operand/result bundle for the
//                sequential divider.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_divider_if #(
    parameter int DIVIDEND = 16,
    parameter int DIVISOR  = 8
);
    logic                start;
    logic [DIVIDEND-1:0] dividend;
    logic [DIVISOR-1:0]  divisor;
    logic                ready;
    logic                done;
    logic [DIVIDEND-1:0] quotient;
    logic [DIVISOR-1:0]  remainder;
    logic                div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Radix-2 restoring divider, one quotient bit per clock, with
//                optional two's-complement mode and divide-by-zero reporting.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int DIVIDEND = 16,
    parameter int DIVISOR  = 8,
    parameter bit SIGNED   = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);

    localparam int              c_CW       = $clog2(DIVIDEND + 1);
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(DIVIDEND);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CW-1:0]     r_cnt;
    logic [DIVIDEND-1:0] r_work;
    logic [DIVISOR-1:0]  r_rem;
    logic [DIVISOR-1:0]  r_dvsr;
    logic                r_dbz_op;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DIVIDEND-1:0] r_quotient;
    logic [DIVISOR-1:0]  r_remainder;
    logic                r_div_by_zero;

    logic                w_accept;
    logic                w_last;
    logic                w_neg_a;
    logic                w_neg_b;
    logic                w_dvsr_zero;
    logic [DIVIDEND-1:0] w_mag_a;
    logic [DIVISOR-1:0]  w_mag_b;
    logic [DIVISOR:0]    w_shift;
    logic [DIVISOR+1:0]  w_diff;
    logic                w_qbit;
    logic [DIVISOR-1:0]  w_rem_nxt;
    logic [DIVIDEND-1:0] w_work_nxt;
    logic [DIVIDEND-1:0] w_q_fin;
    logic [DIVISOR-1:0]  w_r_fin;
    logic                w_unused_ok;

    assign w_accept    = (r_state != c_RUN) && bus.start;
    assign w_last      = (r_state == c_RUN) && (r_cnt == c_CNT_ONE);
    assign w_dvsr_zero = (bus.divisor == '0);

    // Operands are reduced to magnitudes; signs are reapplied on the DONE edge.
    assign w_neg_a = SIGNED && bus.dividend[DIVIDEND-1];
    assign w_neg_b = SIGNED && bus.divisor[DIVISOR-1];
    assign w_mag_a = w_neg_a ? -bus.dividend : bus.dividend;
    assign w_mag_b = w_neg_b ? -bus.divisor  : bus.divisor;

    // Kept remainder is always below the divisor, so DIVISOR bits hold it.
    assign w_shift     = {r_rem, r_work[DIVIDEND-1]};
    assign w_diff      = {1'b0, w_shift} - {2'b00, r_dvsr};
    assign w_qbit      = ~w_diff[DIVISOR+1];
    assign w_rem_nxt   = w_qbit ? w_diff[DIVISOR-1:0] : w_shift[DIVISOR-1:0];
    assign w_work_nxt  = {r_work[DIVIDEND-2:0], w_qbit};
    assign w_unused_ok = w_diff[DIVISOR];

    assign w_q_fin = r_neg_q ? -w_work_nxt : w_work_nxt;
    assign w_r_fin = r_neg_r ? -w_rem_nxt  : w_rem_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_state_nxt = c_RUN;
            c_RUN:   if (w_last)    w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = bus.start ? c_RUN : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // A zero divisor spends a single cycle in RUN so its done lands after E0+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_work        <= '0;
            r_rem         <= '0;
            r_dvsr        <= '0;
            r_dbz_op      <= 1'b0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_dbz_op <= w_dvsr_zero;
            r_cnt    <= w_dvsr_zero ? c_CNT_ONE : c_CNT_INIT;
            r_work   <= w_dvsr_zero ? bus.dividend : w_mag_a;
            r_dvsr   <= w_mag_b;
            r_rem    <= '0;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
        end else if (r_state == c_RUN) begin
            r_cnt <= r_cnt - c_CNT_ONE;
            if (!r_dbz_op) begin
                r_rem  <= w_rem_nxt;
                r_work <= w_work_nxt;
            end
            if (w_last) begin
                if (r_dbz_op) begin
                    r_quotient    <= '1;
                    r_remainder   <= r_work[DIVISOR-1:0];
                    r_div_by_zero <= 1'b1;
                end else begin
                    r_quotient    <= w_q_fin;
                    r_remainder   <= w_r_fin;
                    r_div_by_zero <= 1'b0;
                end
            end
        end
    end

    assign bus.ready       = (r_state != c_RUN);
    assign bus.done        = (r_state == c_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
